// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Shares one FIFO write port between two valid/ready sources.
//            Round-robin bursts of up to pBURST words, full-aware writes,
//            saturating per-source word counters and a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int pDATA_WIDTH = 16,
  parameter int pBURST      = 8,
  parameter int pCNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   src0_valid,
  input  logic [pDATA_WIDTH-1:0] src0_data,
  output logic                   src0_ready,
  input  logic                   src1_valid,
  input  logic [pDATA_WIDTH-1:0] src1_data,
  output logic                   src1_ready,
  output logic                   fifo_wen,
  output logic [pDATA_WIDTH-1:0] fifo_wdata,
  input  logic                   fifo_full,
  input  logic                   fifo_overflow,
  output logic [1:0]             grant,
  input  logic                   cnt_clear,
  output logic [pCNT_WIDTH-1:0]  src0_count,
  output logic [pCNT_WIDTH-1:0]  src1_count,
  output logic                   overflow_sticky
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_GNT0 = 2'd1;
  localparam logic [1:0] c_GNT1 = 2'd2;

  // Burst counter value at which the accepted word is the last of the burst
  localparam logic [7:0] c_BURST_LAST = 8'(pBURST - 1);

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic                  r_ptr;        // 0: source 0 wins a tie, 1: source 1
  logic [7:0]            r_burst;
  logic                  w_grant_end;
  logic                  w_accept0;
  logic                  w_accept1;
  logic [pCNT_WIDTH-1:0] r_src0_count;
  logic [pCNT_WIDTH-1:0] r_src1_count;
  logic                  r_overflow_sticky;

  // Arbitration rule shared by IDLE and by the end of a grant
  function automatic logic [1:0] f_pick(input logic v0, input logic v1,
                                        input logic ptr);
    logic [1:0] sel;
    if (v0 && v1)  sel = ptr ? c_GNT1 : c_GNT0;
    else if (v0)   sel = c_GNT0;
    else if (v1)   sel = c_GNT1;
    else           sel = c_IDLE;
    return sel;
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state: grant ends on a completed burst or a gap in the owner's valid;
  // the pointer handed to f_pick is the one that will be in effect afterwards
  always_comb begin
    w_next_state = r_state;
    w_grant_end  = 1'b0;
    case (r_state)
      c_IDLE: w_next_state = f_pick(src0_valid, src1_valid, r_ptr);
      c_GNT0: begin
        if (!src0_valid || (w_accept0 && (r_burst == c_BURST_LAST))) begin
          w_grant_end  = 1'b1;
          w_next_state = f_pick(src0_valid, src1_valid, 1'b1);
        end
      end
      c_GNT1: begin
        if (!src1_valid || (w_accept1 && (r_burst == c_BURST_LAST))) begin
          w_grant_end  = 1'b1;
          w_next_state = f_pick(src0_valid, src1_valid, 1'b0);
        end
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  // Outputs: ready/write gated by full, data passed straight through
  always_comb begin
    src0_ready = 1'b0;
    src1_ready = 1'b0;
    fifo_wdata = '0;
    grant      = 2'b00;
    case (r_state)
      c_GNT0: begin
        src0_ready = !fifo_full;
        fifo_wdata = src0_data;
        grant      = 2'b01;
      end
      c_GNT1: begin
        src1_ready = !fifo_full;
        fifo_wdata = src1_data;
        grant      = 2'b10;
      end
      default: ;
    endcase
    w_accept0 = src0_ready && src0_valid;
    w_accept1 = src1_ready && src1_valid;
    fifo_wen  = w_accept0 || w_accept1;
  end

  // Burst length tracking and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_burst <= 8'd0;
      r_ptr   <= 1'b0;
    end else if (w_grant_end) begin
      r_burst <= 8'd0;
      r_ptr   <= (r_state == c_GNT0);
    end else if (w_accept0 || w_accept1) begin
      r_burst <= r_burst + 8'd1;
    end
  end

  // Saturating per-source word counters; a clear beats a same-cycle accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src0_count <= '0;
      r_src1_count <= '0;
    end else if (cnt_clear) begin
      r_src0_count <= '0;
      r_src1_count <= '0;
    end else begin
      if (w_accept0 && (r_src0_count != {pCNT_WIDTH{1'b1}}))
        r_src0_count <= r_src0_count + 1'b1;
      if (w_accept1 && (r_src1_count != {pCNT_WIDTH{1'b1}}))
        r_src1_count <= r_src1_count + 1'b1;
    end
  end

  // Sticky overflow flag; a new overflow beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              r_overflow_sticky <= 1'b0;
    else if (fifo_overflow) r_overflow_sticky <= 1'b1;
    else if (cnt_clear)     r_overflow_sticky <= 1'b0;
  end

  assign src0_count      = r_src0_count;
  assign src1_count      = r_src1_count;
  assign overflow_sticky = r_overflow_sticky;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Self-checking bench for fifo_wr_arbiter: cycle-level model plus
//            directed scenarios with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int BURST = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        src0_valid = 1'b0, src1_valid = 1'b0;
  logic [15:0] src0_data = 16'h0000, src1_data = 16'h1000;
  logic        fifo_full = 1'b0, fifo_overflow = 1'b0, cnt_clear = 1'b0;

  logic        src0_ready, src1_ready, fifo_wen, overflow_sticky;
  logic [15:0] fifo_wdata, src0_count, src1_count;
  logic [1:0]  grant;

  logic        s_src0_ready, s_src1_ready, s_fifo_wen, s_overflow_sticky;
  logic [15:0] s_fifo_wdata;
  logic [3:0]  s_src0_count, s_src1_count;
  logic [1:0]  s_grant;

  int checks = 0;
  int errors = 0;
  logic [15:0] cap[$];

  always #5 clk = ~clk;

  fifo_wr_arbiter u_dut (
    .clk(clk), .reset(reset),
    .src0_valid(src0_valid), .src0_data(src0_data), .src0_ready(src0_ready),
    .src1_valid(src1_valid), .src1_data(src1_data), .src1_ready(src1_ready),
    .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .fifo_overflow(fifo_overflow), .grant(grant), .cnt_clear(cnt_clear),
    .src0_count(src0_count), .src1_count(src1_count),
    .overflow_sticky(overflow_sticky)
  );

  fifo_wr_arbiter #(.pCNT_WIDTH(4)) u_sat (
    .clk(clk), .reset(reset),
    .src0_valid(src0_valid), .src0_data(src0_data), .src0_ready(s_src0_ready),
    .src1_valid(src1_valid), .src1_data(src1_data), .src1_ready(s_src1_ready),
    .fifo_wen(s_fifo_wen), .fifo_wdata(s_fifo_wdata), .fifo_full(fifo_full),
    .fifo_overflow(fifo_overflow), .grant(s_grant), .cnt_clear(cnt_clear),
    .src0_count(s_src0_count), .src1_count(s_src1_count),
    .overflow_sticky(s_overflow_sticky)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_owner = -1;   // -1 none, 0 or 1 = source holding the FIFO
  int m_ptr   = 0;
  int m_burst = 0;
  int m_c0 = 0, m_c1 = 0, m_s0 = 0, m_s1 = 0;
  bit m_sticky = 0;

  function automatic int pick(bit v0, bit v1, int p);
    if (v0 && v1) return p;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    bit a0, a1, vown;
    int no, np, nb;
    if (reset) begin
      m_owner <= -1; m_ptr <= 0; m_burst <= 0;
      m_c0 <= 0; m_c1 <= 0; m_s0 <= 0; m_s1 <= 0; m_sticky <= 0;
    end else begin
      a0 = (m_owner == 0) && src0_valid && !fifo_full;
      a1 = (m_owner == 1) && src1_valid && !fifo_full;
      if (cnt_clear) begin
        m_c0 <= 0; m_c1 <= 0; m_s0 <= 0; m_s1 <= 0;
      end else begin
        if (a0) begin m_c0 <= (m_c0 < 65535) ? m_c0 + 1 : m_c0; m_s0 <= (m_s0 < 15) ? m_s0 + 1 : m_s0; end
        if (a1) begin m_c1 <= (m_c1 < 65535) ? m_c1 + 1 : m_c1; m_s1 <= (m_s1 < 15) ? m_s1 + 1 : m_s1; end
      end
      if (fifo_overflow) m_sticky <= 1;
      else if (cnt_clear) m_sticky <= 0;
      no = m_owner; np = m_ptr; nb = m_burst;
      if (m_owner < 0) begin
        no = pick(src0_valid, src1_valid, m_ptr);
      end else begin
        vown = (m_owner == 0) ? src0_valid : src1_valid;
        if (a0 || a1) nb = nb + 1;
        if (!vown || nb == BURST) begin
          nb = 0;
          np = 1 - m_owner;
          no = pick(src0_valid, src1_valid, np);
        end
      end
      m_owner <= no; m_ptr <= np; m_burst <= nb;
    end
  end

  // Compare every cycle mid-period, and record what the FIFO receives
  always @(negedge clk) begin : compare
    logic [1:0]  eg;
    logic [15:0] ed;
    bit          ew;
    eg = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    ed = (m_owner == 0) ? src0_data : (m_owner == 1) ? src1_data : 16'h0;
    ew = ((m_owner == 0) && src0_valid || (m_owner == 1) && src1_valid) && !fifo_full;
    chk("m_grant", 32'(grant), 32'(eg));
    chk("m_ready0", 32'(src0_ready), 32'((m_owner == 0) && !fifo_full));
    chk("m_ready1", 32'(src1_ready), 32'((m_owner == 1) && !fifo_full));
    chk("m_wen", 32'(fifo_wen), 32'(ew));
    chk("m_wdata", 32'(fifo_wdata), 32'(ed));
    chk("m_cnt0", 32'(src0_count), 32'(m_c0));
    chk("m_cnt1", 32'(src1_count), 32'(m_c1));
    chk("m_sat0", 32'(s_src0_count), 32'(m_s0));
    chk("m_sat1", 32'(s_src1_count), 32'(m_s1));
    chk("m_sticky", 32'(overflow_sticky), 32'(m_sticky));
    chk("m_sat_sticky", 32'(s_overflow_sticky), 32'(m_sticky));
    if (!reset && fifo_wen) cap.push_back(fifo_wdata);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    logic a0, a1;
    @(negedge clk);
    a0 = src0_valid && src0_ready;
    a1 = src1_valid && src1_ready;
    @(posedge clk);
    #1;
    if (a0) src0_data = src0_data + 16'd1;
    if (a1) src1_data = src1_data + 16'd1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    src0_valid = 0; src1_valid = 0; fifo_full = 0; fifo_overflow = 0; cnt_clear = 0;
    src0_data = 16'h0000; src1_data = 16'h1000;
    @(posedge clk); #1;
    reset = 1'b0;
    cap.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int b, idx;
    logic [15:0] ev;

    // Reset state
    do_reset;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_wen", 32'(fifo_wen), 32'h0);
    chk("rst_cnt0", 32'(src0_count), 32'h0);
    chk("rst_sticky", 32'(overflow_sticky), 32'h0);

    // Single source, 20 words, no gaps between bursts
    src0_valid = 1;
    #1;
    chk("t1_idle_grant", 32'(grant), 32'h0);
    chk("t1_idle_wen", 32'(fifo_wen), 32'h0);
    tick;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("t1_grant", 32'(grant), 32'h1);
      chk("t1_wen", 32'(fifo_wen), 32'h1);
      chk("t1_wdata", 32'(fifo_wdata), 32'(i));
      tick;
    end
    chk("t1_nwords", 32'(cap.size()), 32'd20);
    for (int i = 0; i < 20 && i < cap.size(); i++) chk("t1_order", 32'(cap[i]), 32'(i));
    chk("t1_cnt0", 32'(src0_count), 32'd20);
    chk("t1_sat0", 32'(s_src0_count), 32'd15);
    fifo_overflow = 1; tick; fifo_overflow = 0;
    #1;
    chk("t1_sticky_set", 32'(overflow_sticky), 32'h1);
    chk("t1_cnt0_21", 32'(src0_count), 32'd21);
    cnt_clear = 1; fifo_overflow = 1; tick; cnt_clear = 0; fifo_overflow = 0;
    #1;
    chk("t1_clr_cnt0", 32'(src0_count), 32'd0);
    chk("t1_clr_sat0", 32'(s_src0_count), 32'd0);
    chk("t1_clr_sticky_wins", 32'(overflow_sticky), 32'h1);
    cnt_clear = 1; tick; cnt_clear = 0;
    #1;
    chk("t1_clr_sticky", 32'(overflow_sticky), 32'h0);
    chk("t1_clr_accept", 32'(src0_count), 32'd0);

    // Both sources continuously valid: alternating 8-word bursts
    do_reset;
    src0_valid = 1; src1_valid = 1;
    tick;
    repeat (32) tick;
    chk("t2_nwords", 32'(cap.size()), 32'd32);
    for (int k = 0; k < 32 && k < cap.size(); k++) begin
      b   = k / BURST;
      idx = (b / 2) * BURST + (k % BURST);
      ev  = (b % 2) ? 16'(16'h1000 + idx) : 16'(idx);
      chk("t2_order", 32'(cap[k]), 32'(ev));
    end
    chk("t2_cnt0", 32'(src0_count), 32'd16);
    chk("t2_cnt1", 32'(src1_count), 32'd16);
    #1;
    chk("t2_next_grant", 32'(grant), 32'h1);

    // FIFO full for 5 cycles mid-burst in GNT1
    do_reset;
    src1_valid = 1;
    tick;
    repeat (3) tick;
    fifo_full = 1; src0_valid = 1;
    repeat (5) begin
      #1;
      chk("t3_stall_wen", 32'(fifo_wen), 32'h0);
      chk("t3_stall_ready1", 32'(src1_ready), 32'h0);
      chk("t3_stall_grant", 32'(grant), 32'h2);
      tick;
    end
    fifo_full = 0;
    #1;
    chk("t3_release_wen", 32'(fifo_wen), 32'h1);
    repeat (5) tick;
    #1;
    chk("t3_rearb_grant", 32'(grant), 32'h1);
    chk("t3_cnt1", 32'(src1_count), 32'd8);
    chk("t3_nwords", 32'(cap.size()), 32'd8);
    if (cap.size() == 8) chk("t3_last", 32'(cap[7]), 32'h1007);

    // Source 0 drops after 2 words while source 1 waits
    do_reset;
    src0_valid = 1; src1_valid = 1;
    tick;
    repeat (2) tick;
    src0_valid = 0;
    tick;
    #1;
    chk("t4_grant", 32'(grant), 32'h2);
    chk("t4_wen", 32'(fifo_wen), 32'h1);
    chk("t4_wdata", 32'(fifo_wdata), 32'h1000);

    // Asynchronous reset 4 words into a GNT0 burst
    do_reset;
    src0_valid = 1;
    tick;
    repeat (4) tick;
    #1;
    reset = 1;
    #1;
    chk("t5_async_grant", 32'(grant), 32'h0);
    chk("t5_async_ready0", 32'(src0_ready), 32'h0);
    chk("t5_async_wen", 32'(fifo_wen), 32'h0);
    @(posedge clk); #1;
    reset = 0;
    cap.delete();
    #1;
    chk("t5_idle", 32'(grant), 32'h0);
    tick;
    repeat (BURST) tick;
    chk("t5_nwords", 32'(cap.size()), 32'd8);
    if (cap.size() == 8) begin
      chk("t5_first", 32'(cap[0]), 32'h4);
      chk("t5_last", 32'(cap[7]), 32'hB);
    end
    chk("t5_cnt0", 32'(src0_count), 32'd8);
    #1;
    chk("t5_regrant", 32'(grant), 32'h1);

    src0_valid = 0;
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write port of one fifo_sync instance between two independent 16-bit streaming sources.
- Each source uses a valid/ready handshake. The block grants the FIFO to one source at a time, in bursts of up to pBURST words, with round-robin fairness.
- Full handling: it never writes into a full FIFO. It also keeps per-source word counters and a sticky FIFO overflow flag for firmware.
- Sits directly in front of the FIFO's wen/wdata/full/overflow pins.

Parameters:
- pDATA_WIDTH, 16, width of source data and of the FIFO write data.
- pBURST, 8, maximum words accepted per grant before re-arbitration; legal range 1 to 255.
- pCNT_WIDTH, 16, width of the per-source saturating word counters.

Ports:
- clk  input  1  single clock for the block and the FIFO write side.
- reset  input  1  asynchronous, active-high reset.
- src0_valid  input  1  source 0 has a word.
- src0_data  input  pDATA_WIDTH  source 0 word.
- src0_ready  output  1  source 0 word accepted this cycle when valid and ready are both high.
- src1_valid  input  1  source 1 has a word.
- src1_data  input  pDATA_WIDTH  source 1 word.
- src1_ready  output  1  source 1 word accepted this cycle when valid and ready are both high.
- fifo_wen  output  1  write enable to the FIFO.
- fifo_wdata  output  pDATA_WIDTH  write data to the FIFO.
- fifo_full  input  1  FIFO full flag.
- fifo_overflow  input  1  FIFO overflow pulse.
- grant  output  2  one-hot current grant: 01 is source 0, 10 is source 1, 00 is idle.
- cnt_clear  input  1  synchronous clear of counters and the sticky flag.
- src0_count  output  pCNT_WIDTH  words written from source 0, saturating.
- src1_count  output  pCNT_WIDTH  words written from source 1, saturating.
- overflow_sticky  output  1  set on any fifo_overflow; held until cnt_clear.

Behaviour:
- Reset values:
  - State is IDLE, grant = 00, priority pointer = source 0.
  - Burst counter, src0_count, src1_count and overflow_sticky are all 0.
  - fifo_wen, src0_ready and src1_ready are 0.
- States:
  - IDLE: no grant.
  - GNT0: source 0 owns the FIFO.
  - GNT1: source 1 owns the FIFO.
- IDLE transitions:
  - Only src0_valid high: go to GNT0.
  - Only src1_valid high: go to GNT1.
  - Both high: grant the source named by the priority pointer.
  - Neither high: stay in IDLE.
  - Arbitration latency is one cycle. No word is accepted in the IDLE cycle.
- Ready and write (combinational, in GNTi):
  - srci_ready = not fifo_full; the other source's ready is 0.
  - fifo_wen = srci_valid and not fifo_full.
  - fifo_wdata = srci_data, zero-latency pass-through.
  - In IDLE, fifo_wdata = 0.
- Burst counting and grant release:
  - Each accepted word increments the burst counter.
  - The grant ends after the cycle in which the pBURST-th word is accepted.
  - The grant also ends after any cycle in GNTi with srci_valid low. A full FIFO with valid high does not end the grant; the block stalls in place.
- On grant end:
  - Clear the burst counter.
  - Set the priority pointer to the other source.
  - Re-evaluate the requests immediately, without passing through IDLE, using the same rules as IDLE.
  - Consequence: if the other source is valid, GNTi goes directly to GNT(other). If only the same source is valid, it is re-granted for a new burst.
- Full boundary: fifo_wen is never asserted while fifo_full is high. A word is accepted in the cycle fifo_full falls.
- Counters:
  - srci_count increments on every accepted word from source i.
  - It saturates at all-ones and does not wrap.
- overflow_sticky is set on fifo_overflow and cleared only by cnt_clear or reset.
- Simultaneous events:
  - cnt_clear together with an accept: the counter becomes 0; the clear wins.
  - cnt_clear together with fifo_overflow: overflow_sticky becomes 1; the set wins.
- Reset mid-burst:
  - All state returns to reset values immediately and asynchronously.
  - ready and wen drop in the same cycle.
  - The partial burst is abandoned; the sources hold their data per the handshake rules.

Test Plan:
- Single source: src0_valid held high, 20 words 0x0000..0x0013, FIFO never full.
  - Required: IDLE for one cycle, then writes in bursts of 8.
  - Between bursts, the grant passes straight from GNT0 back to GNT0 with no gap cycle.
  - FIFO holds 20 words in order; src0_count = 20.
- Both sources continuously valid:
  - Required grant order GNT0 (8 words), GNT1 (8 words), GNT0, and so on, with no IDLE cycles.
  - fifo_wdata alternates 8-word groups from each source.
- fifo_full forced high for 5 cycles mid-burst in GNT1, after 3 words:
  - Required: fifo_wen = 0 and src1_ready = 0 for 5 cycles, grant stays 10.
  - After release, 5 more words complete the burst, then re-arbitration.
- src0_valid drops after 2 words while src1 is valid:
  - Required: in the next cycle, grant = 10 and source 1 is written.
- Saturation with pCNT_WIDTH = 4: 20 words from source 0.
  - Required: src0_count = 15.
  - Pulse fifo_overflow: overflow_sticky = 1.
  - Assert cnt_clear on the same cycle as a second fifo_overflow: count = 0, sticky = 1.
- Assert reset while GNT0 is 4 words into a burst:
  - Required: grant = 00, src0_ready = 0 and fifo_wen = 0 without waiting for a clock edge.
  - After release, a fresh burst of up to 8 words.
